div: RTL and testbench
======================

Name: div

Overview:
- Signed 32-bit iterative divider. The division counterpart of the sequential multiplier in the CPU's MULT/DIV unit.
- Takes dividend a and divisor b on a one-cycle start pulse and runs one restoring-division step per clock.
- Writes quotient to lo and remainder to hi, using MIPS DIV semantics.
- Pulses divStop on completion and divZero on a zero divisor; the control unit waits on these pulses before MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and result width. The iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset (asserted when 0)
- a  input  WIDTH  dividend, two's complement, sampled only on the start edge
- b  input  WIDTH  divisor, two's complement, sampled only on the start edge
- divControl  input  1  start pulse, high for one cycle
- divStop  output  1  one-cycle done pulse; hi/lo are valid from this cycle on
- divZero  output  1  one-cycle divide-by-zero pulse
- hi  output  WIDTH  remainder, registered
- lo  output  WIDTH  quotient, registered

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE.
  - hi=0, lo=0, divStop=0, divZero=0.
  - All internal registers cleared.
  - Reset takes effect immediately, including mid-operation; the aborted result is never written.
- States: IDLE, CALC, FIX.
- IDLE:
  - divStop=0 and divZero=0 (each pulse lasts exactly one cycle).
  - Edge E0 with divControl=1 and b!=0:
    - capture |a| and |b| as unsigned WIDTH-bit magnitudes;
    - capture sign flags sa=a[WIDTH-1] and sq=a[WIDTH-1]^b[WIDTH-1];
    - clear remainder register R and iteration counter; go to CALC.
  - Edge E0 with divControl=1 and b==0:
    - divZero=1 for the following cycle; stay IDLE;
    - hi and lo are unchanged; divStop is not asserted.
- CALC, one iteration per edge, E1..E32:
  - shift {R,Q} left by 1, bringing in the next dividend bit at Q[0];
  - trial T = R - |b|, computed at WIDTH+1 bits;
  - if T is non-negative: R=T and Q[0]=1; otherwise R is kept and Q[0]=0;
  - after WIDTH iterations, go to FIX.
- FIX (edge E33):
  - lo = sq ? -Q : Q;
  - hi = sa ? -R : R;
  - divStop=1 for the following cycle; return to IDLE.
- Latency: divStop is high in the cycle after E33, i.e. 33 clocks after the start edge. hi and lo update on the same edge that raises divStop.
- Result rules:
  - quotient truncates toward zero;
  - remainder takes the dividend's sign;
  - a = hi + lo*b holds in WIDTH-bit arithmetic.
- Overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No flag is raised.
- Restart: divControl=1 while in CALC or FIX aborts the current operation and restarts from E0 with the new operands. The aborted result is never written and divStop is not pulsed for it.
- Start edge coinciding with the FIX edge: the restart wins and hi/lo are not updated.
- hi and lo hold their values between operations. Only a completed FIX or Reset changes them.
- divControl in IDLE with the same operands as last time simply recomputes. There is no caching.

Decomposition:
- Shared package mult_div_pkg:
  - typedef enum of div states {IDLE, CALC, FIX};
  - localparam DIV_WIDTH=32;
  - localparam DIV_CYCLES=DIV_WIDTH+1.
- The package is also importable by mult.
- One natural sub-module, div_step: combinational shift/trial-subtract/select for one iteration. It is instantiated once, and the counter and state stay in div.

Test Plan:
- a=7, b=2, divControl pulse -> divStop rises 33 cycles later; lo=3, hi=1; divZero stays 0.
- a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, divStop pulses once. Also a=5, b=7 -> lo=0, hi=5.
- Preload hi=1/lo=3 via a 7/2 op, then a=9, b=0 -> divZero=1 for exactly one cycle, divStop never rises, hi=1 and lo=3 unchanged.
- Start 100/7, pull Reset low at cycle 10 -> hi, lo, divStop and divZero all 0 immediately. After release, a new 100/7 -> lo=14, hi=2 after 33 cycles.
- Start 100/7, re-pulse divControl with 50/5 at cycle 20 -> exactly one divStop, 33 cycles after the second pulse, with lo=10, hi=0.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared definitions for the MULT/DIV unit: divider width, latency and FSM states.
package mult_div_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_CYCLES = DIV_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_if.sv
// Operand/result bundle between the control unit (master) and the divider (slave).
interface div_if
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             divControl;
    logic             divStop;
    logic             divZero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output a, b, divControl,
        input  divStop, divZero, hi, lo
    );

    modport slave (
        input  a, b, divControl,
        output divStop, divZero, hi, lo
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor, select.
module div_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < dvs always holds, so the shifted partial remainder fits in WIDTH+1 bits
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_i};
        quo_o   = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
        rem_o   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end
endmodule

// File: rtl/div.sv
// Signed iterative divider with MIPS DIV semantics: quotient to lo, remainder to hi.
// state | meaning
// IDLE  | waiting for divControl; hi/lo hold the last completed result
// CALC  | one restoring step per clock, WIDTH steps total
// FIX   | apply signs, write hi/lo, pulse divStop
module div
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic  clk,
    input  logic  Reset,
    div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sa_q, sa_d;
    logic             sq_q, sq_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             stop_q, stop_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // 0x80000000 maps to itself, which is the correct unsigned magnitude
    assign mag_a = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
    assign mag_b = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sa_d    = sa_q;
        sq_d    = sq_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stop_d  = 1'b0;
        zero_d  = 1'b0;

        // A start in any state aborts whatever is in flight
        if (bus.divControl) begin
            if (bus.b == '0) begin
                zero_d  = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = CALC;
                cnt_d   = CW'(WIDTH - 1);
                rem_d   = '0;
                quo_d   = mag_a;
                dvs_d   = mag_b;
                sa_d    = bus.a[WIDTH-1];
                sq_d    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            end
        end else begin
            case (state_q)
                CALC: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    lo_d    = sq_q ? (~quo_q + 1'b1) : quo_q;
                    hi_d    = sa_q ? (~rem_q + 1'b1) : rem_q;
                    stop_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            sa_q    <= 1'b0;
            sq_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            stop_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sa_q    <= sa_d;
            sq_q    <= sq_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            stop_q  <= stop_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.divStop = stop_q;
    assign bus.divZero = zero_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: stimulus pushes expected pulses, a negedge monitor pops and checks.
module tb_div;
    import mult_div_pkg::*;

    typedef struct {
        bit          zero;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic Reset;
    int   cyc;
    int   tests;
    int   fails;
    exp_t sb[$];

    div_if #(.WIDTH(DIV_WIDTH)) bus ();

    div #(.WIDTH(DIV_WIDTH)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: all comparisons happen here
    always @(negedge clk) begin
        exp_t e;
        if (!Reset) begin
            tests = tests + 1;
            if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.divStop !== 1'b0 || bus.divZero !== 1'b0) begin
                fails = fails + 1;
                $display("FAIL reset_state: hi=%h lo=%h stop=%b zero=%b, required all zero",
                         bus.hi, bus.lo, bus.divStop, bus.divZero);
            end
        end else if (bus.divStop === 1'b1 || bus.divZero === 1'b1) begin
            tests = tests + 1;
            if (sb.size() == 0) begin
                fails = fails + 1;
                $display("FAIL unexpected_pulse: stop=%b zero=%b at cycle %0d, required no pulse",
                         bus.divStop, bus.divZero, cyc);
            end else begin
                e = sb.pop_front();
                if (bus.divZero !== e.zero || bus.divStop !== !e.zero) begin
                    fails = fails + 1;
                    $display("FAIL pulse_kind: stop=%b zero=%b, required zero=%b", bus.divStop, bus.divZero, e.zero);
                end
                tests = tests + 3;
                if (cyc != e.cyc) begin
                    fails = fails + 1;
                    $display("FAIL latency: pulse at cycle %0d, required %0d", cyc, e.cyc);
                end
                if (bus.hi !== e.hi) begin
                    fails = fails + 1;
                    $display("FAIL hi: got %h, required %h", bus.hi, e.hi);
                end
                if (bus.lo !== e.lo) begin
                    fails = fails + 1;
                    $display("FAIL lo: got %h, required %h", bus.lo, e.lo);
                end
            end
        end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            tests = tests + 1;
            fails = fails + 1;
            e = sb.pop_front();
            $display("FAIL missing_pulse: expected %s at cycle %0d, still absent at cycle %0d",
                     e.zero ? "divZero" : "divStop", e.cyc, cyc);
        end
    end

    task automatic start(input logic [31:0] a, input logic [31:0] b, input bit push,
                         input bit zero, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        @(negedge clk);
        bus.a          = a;
        bus.b          = b;
        bus.divControl = 1'b1;
        if (push) begin
            e.zero = zero;
            e.cyc  = cyc + (zero ? 1 : DIV_CYCLES + 1);
            e.hi   = ehi;
            e.lo   = elo;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.divControl = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        Reset          = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.divControl = 1'b0;
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        repeat (2) @(negedge clk);

        start(32'd7, 32'd2, 1, 0, 32'd1, 32'd3);                              drain();
        start(32'hFFFFFFF9, 32'd2, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);         drain();
        start(32'd7, 32'hFFFFFFFE, 1, 0, 32'd1, 32'hFFFFFFFD);                drain();
        start(32'h80000000, 32'hFFFFFFFF, 1, 0, 32'd0, 32'h80000000);         drain();
        start(32'd5, 32'd7, 1, 0, 32'd5, 32'd0);                              drain();
        start(32'hFFFFFF9C, 32'hFFFFFFF9, 1, 0, 32'hFFFFFFFE, 32'd14);        drain();
        start(32'd7, 32'd2, 1, 0, 32'd1, 32'd3);                              drain();
        start(32'd7, 32'd2, 1, 0, 32'd1, 32'd3);                              drain();
        start(32'd9, 32'd0, 1, 1, 32'd1, 32'd3);                              drain();
        repeat (40) @(negedge clk);

        // Reset mid-operation: outputs clear immediately and no result appears
        start(32'd100, 32'd7, 0, 0, 32'd0, 32'd0);
        repeat (9) @(posedge clk);
        #1 Reset = 1'b0;
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        repeat (40) @(negedge clk);
        start(32'd100, 32'd7, 1, 0, 32'd2, 32'd14);                           drain();

        // Restart mid-operation: only the second result is delivered
        start(32'd100, 32'd7, 0, 0, 32'd0, 32'd0);
        repeat (18) @(negedge clk);
        start(32'd50, 32'd5, 1, 0, 32'd0, 32'd10);                            drain();
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
